cv32e40px_rf_wb_arbiter: RTL and testbench



---
 rtl/cv32e40px_rf_wb_arbiter.sv | 147 ++++++++++++++
 tb/tb_cv32e40px_rf_wb_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40px_rf_wb_arbiter.sv
// Register-file port B write-back arbiter. It arbitrates between LSU, FPU and X-interface
// with FPU/X round-robin and bounded LSU starvation, and drives one registered write per cycle.
module cv32e40px_rf_wb_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 6,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned X_DUALWRITE  = 0,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,

  input  logic                                 lsu_valid_i,
  output logic                                 lsu_ready_o,
  input  logic [ADDR_WIDTH-1:0]                lsu_addr_i,
  input  logic [DATA_WIDTH-1:0]                lsu_data_i,

  input  logic                                 fpu_valid_i,
  output logic                                 fpu_ready_o,
  input  logic [ADDR_WIDTH-1:0]                fpu_addr_i,
  input  logic [DATA_WIDTH-1:0]                fpu_data_i,

  input  logic                                 x_valid_i,
  output logic                                 x_ready_o,
  input  logic [ADDR_WIDTH-1:0]                x_addr_i,
  input  logic [1:0][DATA_WIDTH-1:0]           x_data_i,
  input  logic                                 x_dual_i,

  output logic [ADDR_WIDTH-1:0]                waddr_b_o,
  output logic [X_DUALWRITE:0][DATA_WIDTH-1:0] wdata_b_o,
  output logic [X_DUALWRITE:0]                 we_b_o,

  output logic                                 pend_valid_o,
  output logic [ADDR_WIDTH-1:0]                pend_addr_o,
  output logic                                 err_dual_o
);

  localparam int unsigned NW  = X_DUALWRITE + 1;
  localparam int unsigned SCW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {RrFpu, RrX} rr_e;

  rr_e                           rr_q, rr_d;
  logic [SCW-1:0]                sc_q, sc_d;
  logic [ADDR_WIDTH-1:0]         waddr_q, waddr_d;
  logic [NW-1:0][DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [NW-1:0]                 we_q, we_d;
  logic                          err_q, err_d;

  logic       starved, other_valid, pick_x, dual_en;
  logic       lsu_gnt, fx_gnt, fpu_gnt, x_gnt;
  logic [1:0] we_full;

  assign other_valid = fpu_valid_i | x_valid_i;
  assign starved     = (sc_q == SCW'(STARVE_LIMIT));
  // X is the FPU/X candidate when it is the only one valid or it holds the round-robin turn.
  assign pick_x      = x_valid_i & (~fpu_valid_i | (rr_q == RrX));
  assign dual_en     = (X_DUALWRITE != 0) && x_dual_i;

  assign lsu_gnt = ~rst & lsu_valid_i & ~starved;
  assign fx_gnt  = ~rst & other_valid & ~lsu_gnt;
  assign fpu_gnt = fx_gnt & ~pick_x;
  assign x_gnt   = fx_gnt & pick_x;

  assign lsu_ready_o = lsu_gnt;
  assign fpu_ready_o = fpu_gnt;
  assign x_ready_o   = x_gnt;

  always_comb begin
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    we_full = 2'b00;
    err_d   = 1'b0;
    if (lsu_gnt) begin
      waddr_d    = lsu_addr_i;
      wdata_d[0] = lsu_data_i;
      we_full    = 2'b01;
    end else if (fpu_gnt) begin
      waddr_d    = fpu_addr_i;
      wdata_d[0] = fpu_data_i;
      we_full    = 2'b01;
    end else if (x_gnt) begin
      waddr_d       = x_addr_i;
      wdata_d[0]    = x_data_i[0];
      // Collapses onto word 0 (same value) when dual write is disabled.
      wdata_d[NW-1] = x_data_i[NW-1];
      if (dual_en) begin
        if (x_addr_i[0]) begin
          we_full = 2'b01;
          err_d   = 1'b1;
        end else begin
          we_full = 2'b11;
        end
      end else begin
        we_full = 2'b01;
      end
    end
    // x0 is hardwired: drop word 0 when it targets address 0.
    if (waddr_d == '0) begin
      we_full[0] = 1'b0;
    end
    we_d = we_full[NW-1:0];
  end

  always_comb begin
    sc_d = sc_q;
    rr_d = rr_q;
    if (fx_gnt || !other_valid) begin
      sc_d = '0;
    end else if (lsu_gnt && !starved) begin
      sc_d = sc_q + SCW'(1);
    end
    if (fpu_gnt) begin
      rr_d = RrX;
    end else if (x_gnt) begin
      rr_d = RrFpu;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q    <= RrFpu;
      sc_q    <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      we_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      rr_q    <= rr_d;
      sc_q    <= sc_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end

  assign waddr_b_o    = waddr_q;
  assign wdata_b_o    = wdata_q;
  assign we_b_o       = we_q;
  assign err_dual_o   = err_q;
  assign pend_valid_o = |we_q;
  assign pend_addr_o  = waddr_q;

  logic unused_x;
  assign unused_x = ^{x_data_i, x_dual_i, we_full};

endmodule

// File: tb/tb_cv32e40px_rf_wb_arbiter.sv
// Bench for cv32e40px_rf_wb_arbiter: directed scenarios plus random traffic,
// scored against a behavioural arbitration model through an expectation queue.
module tb_cv32e40px_rf_wb_arbiter;

  localparam int AW    = 6;
  localparam int DW    = 32;
  localparam int LIMIT = 4;

  typedef struct packed {
    logic [1:0]    we;
    logic [AW-1:0] addr;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    logic          err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                lsu_valid, lsu_ready, fpu_valid, fpu_ready, x_valid, x_ready, x_dual;
  logic [AW-1:0]       lsu_addr, fpu_addr, x_addr, waddr_b, pend_addr;
  logic [DW-1:0]       lsu_data, fpu_data;
  logic [1:0][DW-1:0]  x_data, wdata_b;
  logic [1:0]          we_b;
  logic                pend_valid, err_dual;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  cv32e40px_rf_wb_arbiter #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .X_DUALWRITE (1),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .lsu_valid_i (lsu_valid),
    .lsu_ready_o (lsu_ready),
    .lsu_addr_i  (lsu_addr),
    .lsu_data_i  (lsu_data),
    .fpu_valid_i (fpu_valid),
    .fpu_ready_o (fpu_ready),
    .fpu_addr_i  (fpu_addr),
    .fpu_data_i  (fpu_data),
    .x_valid_i   (x_valid),
    .x_ready_o   (x_ready),
    .x_addr_i    (x_addr),
    .x_data_i    (x_data),
    .x_dual_i    (x_dual),
    .waddr_b_o   (waddr_b),
    .wdata_b_o   (wdata_b),
    .we_b_o      (we_b),
    .pend_valid_o(pend_valid),
    .pend_addr_o (pend_addr),
    .err_dual_o  (err_dual)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    lsu_valid = 0; fpu_valid = 0; x_valid = 0; x_dual = 0;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return '0;
    return AW'($urandom_range(0, 63));
  endfunction

  // Reference model: decides each cycle's winner from the arbitration rules
  // and queues the write the port should show after the next edge.
  initial begin : model
    int            sc_m;
    bit            pref_x;
    logic [AW-1:0] h_addr;
    logic [DW-1:0] h_d0;
    logic          lsu_e, fpu_e, x_e;
    exp_t          e;
    sc_m = 0; pref_x = 0; h_addr = '0; h_d0 = '0;
    forever begin
      @(negedge clk);
      lsu_e = 0; fpu_e = 0; x_e = 0;
      if (rst) begin
        sc_m = 0; pref_x = 0; h_addr = '0; h_d0 = '0;
        exp_q.delete();
      end else if (lsu_valid && sc_m < LIMIT) begin
        lsu_e = 1;
      end else if (fpu_valid && x_valid) begin
        if (pref_x) x_e = 1;
        else fpu_e = 1;
      end else if (fpu_valid) begin
        fpu_e = 1;
      end else if (x_valid) begin
        x_e = 1;
      end
      check("ready", 64'({lsu_ready, fpu_ready, x_ready}), 64'({lsu_e, fpu_e, x_e}));

      e = '{we: 2'b00, addr: h_addr, d0: h_d0, d1: '0, err: 1'b0};
      if (lsu_e) begin
        e.addr = lsu_addr; e.d0 = lsu_data;
        e.we   = (lsu_addr == 0) ? 2'b00 : 2'b01;
      end else if (fpu_e) begin
        e.addr = fpu_addr; e.d0 = fpu_data;
        e.we   = (fpu_addr == 0) ? 2'b00 : 2'b01;
      end else if (x_e) begin
        e.addr = x_addr; e.d0 = x_data[0]; e.d1 = x_data[1];
        if (!x_dual)        e.we = (x_addr == 0) ? 2'b00 : 2'b01;
        else if (x_addr[0]) begin e.we = 2'b01; e.err = 1'b1; end
        else                e.we = (x_addr == 0) ? 2'b10 : 2'b11;
      end
      h_addr = e.addr;
      h_d0   = e.d0;

      if (!rst) begin
        if (fpu_e || x_e || !(fpu_valid || x_valid)) sc_m = 0;
        else if (lsu_e) sc_m = (sc_m + 1 > LIMIT) ? LIMIT : sc_m + 1;
        if (fpu_e) pref_x = 1;
        if (x_e)   pref_x = 0;
      end
      exp_q.push_back(e);
    end
  end

  initial begin : monitor
    exp_t e;
    @(negedge clk);
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_queue got empty expected entry at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("wb", 64'({we_b, waddr_b, wdata_b[0], err_dual}),
              64'({e.we, e.addr, e.d0, e.err}));
        check("pend", 64'({pend_valid, pend_addr}), 64'({|e.we, e.addr}));
        if (e.we[1]) check("wb_hi", 64'(wdata_b[1]), 64'(e.d1));
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin : stim
    logic al, af, ax;
    idle();
    lsu_addr = '0; lsu_data = '0; fpu_addr = '0; fpu_data = '0; x_addr = '0; x_data = '0;
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_we", 64'(we_b), 64'(0));
    rst = 0;

    // LSU only
    lsu_valid = 1; lsu_addr = 5; lsu_data = 32'hDEADBEEF;
    #1 check("lsu_rdy", 64'(lsu_ready), 64'(1));
    tick(); lsu_valid = 0;
    check("lsu_we", 64'({we_b, waddr_b, wdata_b[0]}), 64'({2'b01, 6'd5, 32'hDEADBEEF}));
    check("lsu_pend", 64'({pend_valid, pend_addr}), 64'({1'b1, 6'd5}));
    tick();
    check("lsu_we_off", 64'(we_b), 64'(0));

    // Round robin, run twice: FPU, X, then FPU again
    for (int rep = 0; rep < 2; rep++) begin
      fpu_valid = 1; fpu_addr = 33; fpu_data = 32'h11;
      x_valid = 1; x_addr = 7; x_data[0] = 32'h22; x_dual = 0;
      #1 check("rr_fpu_first", 64'({fpu_ready, x_ready}), 64'(2'b10));
      tick(); fpu_valid = 0;
      check("rr_fpu_addr", 64'(waddr_b), 64'(33));
      #1 check("rr_x_second", 64'({fpu_ready, x_ready}), 64'(2'b01));
      tick(); x_valid = 0;
      check("rr_x_addr", 64'(waddr_b), 64'(7));
    end

    // Starvation: 4 LSU grants, then FPU; repeated to show the count restarts
    lsu_valid = 1; lsu_addr = 3;
    for (int rep = 0; rep < 2; rep++) begin
      fpu_valid = 1; fpu_addr = 40; fpu_data = 32'h40 + rep;
      for (int i = 0; i < LIMIT; i++) begin
        lsu_data = 32'h100 + i;
        #1 check("starve_lsu", 64'({lsu_ready, fpu_ready}), 64'(2'b10));
        tick();
      end
      #1 check("starve_fpu", 64'({lsu_ready, fpu_ready}), 64'(2'b01));
      tick(); fpu_valid = 0;
      check("starve_fpu_addr", 64'(waddr_b), 64'(40));
    end
    #1 check("starve_resume", 64'(lsu_ready), 64'(1));
    tick(); idle();

    // Dual writes
    x_valid = 1; x_dual = 1; x_addr = 10; x_data[1] = 32'h2; x_data[0] = 32'h1;
    tick(); x_valid = 0;
    check("dual_even", 64'({we_b, waddr_b, err_dual}), 64'({2'b11, 6'd10, 1'b0}));
    check("dual_data", 64'({wdata_b[1], wdata_b[0]}), 64'({32'h2, 32'h1}));
    x_valid = 1; x_addr = 11;
    tick(); x_valid = 0;
    check("dual_odd", 64'({we_b, err_dual}), 64'({2'b01, 1'b1}));
    tick();
    check("dual_err_pulse", 64'({we_b, err_dual}), 64'({2'b00, 1'b0}));
    x_valid = 1; x_addr = 0;
    tick(); x_valid = 0; x_dual = 0;
    check("dual_x0", 64'(we_b), 64'(2'b10));

    // x0 drop
    lsu_valid = 1; lsu_addr = 0; lsu_data = 32'h55;
    #1 check("x0_rdy", 64'(lsu_ready), 64'(1));
    tick(); lsu_valid = 0;
    check("x0_drop", 64'({we_b, pend_valid}), 64'(0));

    // Reset mid-operation
    lsu_valid = 1; lsu_addr = 9; lsu_data = 32'h99;
    tick(); lsu_valid = 0;
    check("mid_we", 64'(we_b), 64'(2'b01));
    #2 rst = 1;
    #1 check("mid_rst_we", 64'({we_b, pend_valid}), 64'(0));
    fpu_valid = 1; fpu_addr = 33; x_valid = 1; x_addr = 7;
    tick(); tick(); rst = 0;
    #1 check("post_rst_fpu", 64'({fpu_ready, x_ready}), 64'(2'b10));
    tick(); fpu_valid = 0;
    tick(); x_valid = 0;

    // Random traffic, checked by the model and monitor
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      al = lsu_valid & lsu_ready;
      af = fpu_valid & fpu_ready;
      ax = x_valid & x_ready;
      @(posedge clk);
      #1;
      if (!lsu_valid || al) begin
        lsu_valid = ($urandom_range(0, 99) < ((c < 1500) ? 85 : 30));
        lsu_addr  = rand_addr();
        lsu_data  = $urandom;
      end
      if (!fpu_valid || af) begin
        fpu_valid = ($urandom_range(0, 99) < 40);
        fpu_addr  = rand_addr();
        fpu_data  = $urandom;
      end
      if (!x_valid || ax) begin
        x_valid   = ($urandom_range(0, 99) < 40);
        x_addr    = rand_addr();
        x_data[0] = $urandom;
        x_data[1] = $urandom;
        x_dual    = 1'($urandom_range(0, 1));
      end
    end
    idle();
    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
